// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC register, single-outstanding imem request FSM, IF/ID register.
// Optional FETCH_SKID_BUFFER_EN keeps a response that lands during a stall instead of re-fetching it.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] next_pc,
    input  logic        redirect,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_plus_4,
    output logic        ifid_valid,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc_plus_4
);

    typedef enum logic {
        S_ISSUE = 1'b0,
        S_WAIT  = 1'b1
    } state_t;

    state_t      state_reg;
    logic [31:0] pc_reg;
    logic        kill_reg;
    logic        ifid_valid_reg;
    logic [31:0] ifid_instr_reg;
    logic [31:0] ifid_pc_plus_4_reg;
    logic        accept;

`ifdef FETCH_SKID_BUFFER_EN
    logic        skid_valid_reg;
    logic [31:0] skid_instr_reg;
    logic [31:0] skid_pc_plus_4_reg;
`endif

    assign pc_plus_4      = pc_reg + 32'd4;
    assign imem_addr      = pc_reg;
    assign imem_req       = !rst && (state_reg == S_ISSUE) && !stall;
    assign accept         = imem_req && imem_ready;
    assign ifid_valid     = ifid_valid_reg;
    assign ifid_instr     = ifid_instr_reg;
    assign ifid_pc_plus_4 = ifid_pc_plus_4_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg          <= S_ISSUE;
            pc_reg             <= RESET_PC;
            kill_reg           <= 1'b0;
            ifid_valid_reg     <= 1'b0;
            ifid_instr_reg     <= NOP_INSTR;
            ifid_pc_plus_4_reg <= 32'h0;
`ifdef FETCH_SKID_BUFFER_EN
            skid_valid_reg     <= 1'b0;
            skid_instr_reg     <= NOP_INSTR;
            skid_pc_plus_4_reg <= 32'h0;
`endif
        end else if (redirect) begin
            pc_reg         <= next_pc;
            ifid_valid_reg <= 1'b0;
            ifid_instr_reg <= NOP_INSTR;
`ifdef FETCH_SKID_BUFFER_EN
            skid_valid_reg <= 1'b0;
`endif
            case (state_reg)
                S_ISSUE: begin
                    if (accept) begin
                        state_reg <= S_WAIT;
                        kill_reg  <= 1'b1;
                    end
                end
                default: begin
`ifdef FETCH_SKID_BUFFER_EN
                    // A held skid entry means memory owes us nothing, so no kill is needed.
                    if (skid_valid_reg || imem_rvalid) begin
`else
                    if (imem_rvalid) begin
`endif
                        state_reg <= S_ISSUE;
                        kill_reg  <= 1'b0;
                    end else begin
                        kill_reg  <= 1'b1;
                    end
                end
            endcase
        end else begin
            case (state_reg)
                S_ISSUE: begin
                    if (accept) begin
                        state_reg <= S_WAIT;
                    end
                end
                default: begin
`ifdef FETCH_SKID_BUFFER_EN
                    if (skid_valid_reg) begin
                        if (!stall) begin
                            ifid_valid_reg     <= 1'b1;
                            ifid_instr_reg     <= skid_instr_reg;
                            ifid_pc_plus_4_reg <= skid_pc_plus_4_reg;
                            skid_valid_reg     <= 1'b0;
                            pc_reg             <= next_pc;
                            state_reg          <= S_ISSUE;
                        end
                    end else if (imem_rvalid) begin
`else
                    if (imem_rvalid) begin
`endif
                        if (kill_reg) begin
                            kill_reg  <= 1'b0;
                            state_reg <= S_ISSUE;
                        end else if (!stall) begin
                            ifid_valid_reg     <= 1'b1;
                            ifid_instr_reg     <= imem_rdata;
                            ifid_pc_plus_4_reg <= pc_plus_4;
                            pc_reg             <= next_pc;
                            state_reg          <= S_ISSUE;
                        end else begin
`ifdef FETCH_SKID_BUFFER_EN
                            skid_valid_reg     <= 1'b1;
                            skid_instr_reg     <= imem_rdata;
                            skid_pc_plus_4_reg <= pc_plus_4;
`else
                            // Drop the word; PC is unchanged so the same address is fetched again.
                            state_reg <= S_ISSUE;
`endif
                        end
                    end
                end
            endcase
        end
    end

endmodule
